rom_loader: RTL



---
 rtl/rom_loader_pkg.sv | 22 ++
 rtl/rom_loader_byte_packer.sv | 35 +++
 rtl/rom_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// Shared types for the boot-time code loader.
// Word type, loader states and word-address helper.
package rom_loader_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_SUM,
    S_DONE,
    S_ERROR
  } loader_state_t;

  function automatic logic [29:0] word_addr(
    input logic [31:0] byte_addr
  );
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/rom_loader_byte_packer.sv
// Little-endian byte-to-word packer.
// Shifts bytes in LSB-first, flags the 4th byte of a word.
module byte_packer
  import rom_loader_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       shift,
  input  logic [7:0] data,
  output word_t      word,
  output logic       full
);

  word_t      sr;
  logic [1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift) begin
      sr  <= {data, sr[31:8]};
      cnt <= cnt + 2'd1;
    end
  end

  // Word is valid combinationally in the cycle its last byte is taken.
  assign word = {data, sr[31:8]};
  assign full = shift && (cnt == 2'd3);

endmodule

// File: rtl/rom_loader.sv
// Streams a length-prefixed, checksummed image into code memory.
// Holds the core in reset until a load completes successfully.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDRESS_BITS = 16,
  parameter int BASE_ADDRESS = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    wr_en,
  output logic [ADDRESS_BITS-1:0] wr_address,
  output word_t                   wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    cpu_hold
);

  localparam int IW = ADDRESS_BITS - 2;
  localparam logic [32:0] CAP = 33'(1) << IW;
  localparam logic [IW-1:0] BASE_W =
    IW'(word_addr(32'(BASE_ADDRESS)));

  loader_state_t state, state_n;

  logic [31:0]   n_q;
  logic [IW-1:0] idx;
  logic [7:0]    sum_q;
  logic [7:0]    sum_n;
  logic          accept;
  logic          clear;
  logic          pk_shift;
  logic          pk_full;
  word_t         pk_word;
  logic          wr_fire;
  logic          last_word;
  logic          idle_like;

  always_comb begin
    in_ready  = 1'b0;
    idle_like = 1'b0;
    unique case (state)
      S_LEN,
      S_DATA,
      S_SUM:   in_ready  = 1'b1;
      default: idle_like = 1'b1;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign clear     = start && idle_like;
  assign pk_shift  = accept && (state != S_SUM);
  assign sum_n     = sum_q + in_data;
  assign wr_fire   = (state == S_DATA) && pk_full;
  assign last_word = (32'(idx) + 32'd1) == n_q;

  byte_packer u_packer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .shift   (pk_shift),
    .data    (in_data),
    .word    (pk_word),
    .full    (pk_full)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE,
      S_DONE,
      S_ERROR: if (start) state_n = S_LEN;
      S_LEN: begin
        if (pk_full) begin
          if ({1'b0, pk_word} > CAP)
            state_n = S_ERROR;
          else if (pk_word == '0)
            state_n = S_SUM;
          else
            state_n = S_DATA;
        end
      end
      S_DATA: if (pk_full && last_word) state_n = S_SUM;
      S_SUM: begin
        if (accept)
          state_n = (sum_n == 8'd0) ? S_DONE : S_ERROR;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q   <= '0;
      idx   <= '0;
      sum_q <= '0;
    end else begin
      if (clear) begin
        idx   <= '0;
        sum_q <= '0;
      end else begin
        if (accept)
          sum_q <= sum_n;
        if (wr_fire)
          idx <= idx + 1'b1;
      end
      if (state == S_LEN && pk_full)
        n_q <= pk_word;
    end
  end

  // Write port registered so wr_en lands one cycle after the 4th byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en      <= 1'b0;
      wr_address <= '0;
      wr_data    <= '0;
    end else begin
      wr_en <= wr_fire;
      if (wr_fire) begin
        wr_address <= {BASE_W + idx, 2'b00};
        wr_data    <= pk_word;
      end
    end
  end

  assign busy     = in_ready;
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERROR);
  assign cpu_hold = busy | ~done;

endmodule
